// File: rtl/sparse_fifo_if.sv
// rtl/sparse_fifo_if.sv - write/read payload and status bundle for sparse_fifo
interface sparse_fifo_if #(
   parameter int CAP_WIDTH = 5,
   parameter int D_WIDTH   = 16,
   parameter int I_WIDTH   = 4
);
   logic                 flush;
   logic                 w_en;
   logic [D_WIDTH-1:0]   data_in;
   logic [I_WIDTH-1:0]   index_in;
   logic                 r_en;
   logic [D_WIDTH-1:0]   data_out;
   logic [I_WIDTH-1:0]   index_out;
   logic                 out_valid;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 almost_empty;
   logic                 almost_full;
   logic [CAP_WIDTH:0]   level;
   logic                 overflow;
   logic                 underflow;

   modport master (
      output flush, w_en, data_in, index_in, r_en,
      input  data_out, index_out, out_valid, fifo_empty, fifo_full,
             almost_empty, almost_full, level, overflow, underflow
   );

   modport slave (
      input  flush, w_en, data_in, index_in, r_en,
      output data_out, index_out, out_valid, fifo_empty, fifo_full,
             almost_empty, almost_full, level, overflow, underflow
   );
endinterface

// File: rtl/sparse_fifo.sv
// rtl/sparse_fifo.sv - data+index FIFO with registered or fall-through read and sticky errors
module sparse_fifo #(
   parameter int CAP_WIDTH = 5,
   parameter int D_WIDTH   = 16,
   parameter int I_WIDTH   = 4,
   parameter int AF_LEVEL  = 2**CAP_WIDTH - 2,
   parameter int AE_LEVEL  = 2,
   parameter int FWFT      = 0
) (
   input logic          clk,
   input logic          rst,
   sparse_fifo_if.slave bus
);
   localparam int DEPTH   = 2**CAP_WIDTH;
   localparam int E_WIDTH = D_WIDTH + I_WIDTH;

   logic [E_WIDTH-1:0]   mem_q [DEPTH];
   logic [CAP_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CAP_WIDTH:0]   level_q, level_d;
   logic [D_WIDTH-1:0]   dout_q, dout_d;
   logic [I_WIDTH-1:0]   iout_q, iout_d;
   logic                 ovalid_q, ovalid_d;
   logic                 ovf_q, ovf_d, unf_q, unf_d;
   logic                 empty, full, bypass, rd_acc, wr_acc;
   logic [E_WIDTH-1:0]   head;

   assign empty  = (level_q == '0);
   assign full   = (level_q == (CAP_WIDTH+1)'(DEPTH));
   assign head   = mem_q[rd_ptr_q];
   // Registered mode hands an empty-FIFO write straight to the output instead of storing it
   assign bypass = (FWFT == 0) && empty && bus.w_en && bus.r_en;
   assign rd_acc = bus.r_en && !empty;
   assign wr_acc = bus.w_en && (!full || rd_acc) && !bypass;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      dout_d   = dout_q;
      iout_d   = iout_q;
      ovalid_d = 1'b0;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         rd_ptr_d = rd_ptr_q + CAP_WIDTH'(rd_acc);
         wr_ptr_d = wr_ptr_q + CAP_WIDTH'(wr_acc);
         level_d  = level_q + (CAP_WIDTH+1)'(wr_acc) - (CAP_WIDTH+1)'(rd_acc);
         ovf_d    = ovf_q | (bus.w_en && full && !rd_acc);
         unf_d    = unf_q | (bus.r_en && empty && !bypass);
         if (bypass) begin
            dout_d   = bus.data_in;
            iout_d   = bus.index_in;
            ovalid_d = 1'b1;
         end else if (rd_acc) begin
            dout_d   = head[E_WIDTH-1:I_WIDTH];
            iout_d   = head[I_WIDTH-1:0];
            ovalid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
         iout_q   <= '0;
         ovalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         iout_q   <= iout_d;
         ovalid_q <= ovalid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Non-blocking write keeps a same-edge read of this slot on the old contents
   always_ff @(posedge clk) begin
      if (rst && !bus.flush && wr_acc) begin
         mem_q[wr_ptr_q] <= {bus.data_in, bus.index_in};
      end
   end

   assign bus.level        = level_q;
   assign bus.fifo_empty   = empty;
   assign bus.fifo_full    = full;
   assign bus.almost_full  = (level_q >= (CAP_WIDTH+1)'(AF_LEVEL));
   assign bus.almost_empty = (level_q <= (CAP_WIDTH+1)'(AE_LEVEL));
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.data_out  = head[E_WIDTH-1:I_WIDTH];
         assign bus.index_out = head[I_WIDTH-1:0];
         assign bus.out_valid = !empty;
      end else begin : g_reg
         assign bus.data_out  = dout_q;
         assign bus.index_out = iout_q;
         assign bus.out_valid = ovalid_q;
      end
   endgenerate
endmodule

// File: tb/tb_sparse_fifo.sv
// tb/tb_sparse_fifo.sv - checks registered and fall-through sparse_fifo against queue models
module tb_sparse_fifo;
   logic        clk = 1'b0;
   logic        rst, flush, w_en, r_en;
   logic [15:0] data_in;
   logic [3:0]  index_in;
   bit          chk_en = 1'b0;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   sparse_fifo_if if0 ();
   sparse_fifo_if if1 ();

   assign if0.flush = flush;  assign if1.flush = flush;
   assign if0.w_en = w_en;    assign if1.w_en = w_en;
   assign if0.r_en = r_en;    assign if1.r_en = r_en;
   assign if0.data_in = data_in;   assign if1.data_in = data_in;
   assign if0.index_in = index_in; assign if1.index_in = index_in;

   sparse_fifo #(.FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   sparse_fifo #(.FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   // Reference state: entries as {data,index} in arrival order
   logic [19:0] q0[$];
   logic [19:0] q1[$];
   logic [15:0] m0_d;
   logic [3:0]  m0_i;
   bit          m0_v, m0_ovf, m0_unf, m1_ovf, m1_unf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   always @(posedge clk) begin
      int  n;
      bit  rd, wr;
      logic [19:0] h;
      if (!rst) begin
         q0.delete(); q1.delete();
         m0_d = '0; m0_i = '0; m0_v = 0;
         m0_ovf = 0; m0_unf = 0; m1_ovf = 0; m1_unf = 0;
      end else if (flush) begin
         q0.delete(); q1.delete();
         m0_v = 0; m0_ovf = 0; m0_unf = 0; m1_ovf = 0; m1_unf = 0;
      end else begin
         n = q0.size();
         if (n == 0 && w_en && r_en) begin
            m0_d = data_in; m0_i = index_in; m0_v = 1;
         end else begin
            rd = r_en && n != 0;
            wr = w_en && (n != 32 || rd);
            if (r_en && n == 0) m0_unf = 1;
            if (w_en && n == 32 && !rd) m0_ovf = 1;
            m0_v = rd;
            if (rd) begin
               h = q0.pop_front();
               m0_d = h[19:4]; m0_i = h[3:0];
            end
            if (wr) q0.push_back({data_in, index_in});
         end
         n = q1.size();
         rd = r_en && n != 0;
         wr = w_en && (n != 32 || rd);
         if (r_en && n == 0) m1_unf = 1;
         if (w_en && n == 32 && !rd) m1_ovf = 1;
         if (rd) void'(q1.pop_front());
         if (wr) q1.push_back({data_in, index_in});
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("lvl0", 32'(if0.level), q0.size());
         chk("empty0", 32'(if0.fifo_empty), 32'(q0.size() == 0));
         chk("full0", 32'(if0.fifo_full), 32'(q0.size() == 32));
         chk("af0", 32'(if0.almost_full), 32'(q0.size() >= 30));
         chk("ae0", 32'(if0.almost_empty), 32'(q0.size() <= 2));
         chk("ovf0", 32'(if0.overflow), 32'(m0_ovf));
         chk("unf0", 32'(if0.underflow), 32'(m0_unf));
         chk("oval0", 32'(if0.out_valid), 32'(m0_v));
         chk("dout0", 32'(if0.data_out), 32'(m0_d));
         chk("iout0", 32'(if0.index_out), 32'(m0_i));
         chk("lvl1", 32'(if1.level), q1.size());
         chk("full1", 32'(if1.fifo_full), 32'(q1.size() == 32));
         chk("ovf1", 32'(if1.overflow), 32'(m1_ovf));
         chk("unf1", 32'(if1.underflow), 32'(m1_unf));
         chk("oval1", 32'(if1.out_valid), 32'(q1.size() != 0));
         if (q1.size() != 0) begin
            chk("dout1", 32'(if1.data_out), 32'(q1[0][19:4]));
            chk("iout1", 32'(if1.index_out), 32'(q1[0][3:0]));
         end
      end
   end

   task automatic step(input bit rn, input bit fl, input bit w, input bit r,
                       input logic [15:0] d, input logic [3:0] ix);
      rst = rn; flush = fl; w_en = w; r_en = r; data_in = d; index_in = ix;
      @(posedge clk);
      #2;
   endtask

   initial begin
      int wp, rp;
      step(0, 0, 0, 0, 16'h0, 4'h0);
      chk_en = 1'b1;
      chk("rst_level", 32'(if0.level), 0);
      chk("rst_empty", 32'(if0.fifo_empty), 1);
      chk("rst_ae", 32'(if0.almost_empty), 1);
      chk("rst_af", 32'(if0.almost_full), 0);
      chk("rst_dout", 32'(if0.data_out), 0);

      // fill
      for (int i = 0; i < 32; i++) begin
         step(1, 0, 1, 0, 16'(i), 4'(i % 16));
         if (i == 28) chk("fill_af29", 32'(if0.almost_full), 0);
         if (i == 29) chk("fill_af30", 32'(if0.almost_full), 1);
      end
      chk("fill_full", 32'(if0.fifo_full), 1);
      chk("fill_level", 32'(if0.level), 32);
      step(1, 0, 1, 0, 16'hDEAD, 4'h7);
      chk("fill_lvl33", 32'(if0.level), 32);
      chk("fill_ovf", 32'(if0.overflow), 1);

      // drain
      for (int i = 0; i < 32; i++) begin
         step(1, 0, 0, 1, 16'h0, 4'h0);
         chk("drain_data", 32'(if0.data_out), i);
         chk("drain_valid", 32'(if0.out_valid), 1);
      end
      chk("drain_empty", 32'(if0.fifo_empty), 1);
      step(1, 0, 0, 1, 16'h0, 4'h0);
      chk("drain_unf", 32'(if0.underflow), 1);
      chk("drain_nval", 32'(if0.out_valid), 0);

      // bypass
      step(1, 1, 0, 0, 16'h0, 4'h0);
      step(1, 0, 1, 1, 16'hABCD, 4'h5);
      chk("byp_data", 32'(if0.data_out), 32'hABCD);
      chk("byp_index", 32'(if0.index_out), 5);
      chk("byp_valid", 32'(if0.out_valid), 1);
      chk("byp_level", 32'(if0.level), 0);
      chk("byp_unf", 32'(if0.underflow), 0);

      // full simultaneous, across pointer wrap
      step(1, 1, 0, 0, 16'h0, 4'h0);
      for (int i = 0; i < 32; i++) step(1, 0, 1, 0, 16'(100 + i), 4'(i));
      for (int k = 0; k < 40; k++) begin
         step(1, 0, 1, 1, 16'(200 + k), 4'(k));
         chk("fs_data", 32'(if0.data_out), (k < 32) ? 100 + k : 200 + k - 32);
         chk("fs_level", 32'(if0.level), 32);
      end
      chk("fs_ovf", 32'(if0.overflow), 0);

      // fall-through
      step(1, 1, 0, 0, 16'h0, 4'h0);
      step(1, 0, 1, 0, 16'h1111, 4'h2);
      chk("fwft_data", 32'(if1.data_out), 32'h1111);
      chk("fwft_valid", 32'(if1.out_valid), 1);
      step(1, 0, 0, 1, 16'h0, 4'h0);
      chk("fwft_pop", 32'(if1.out_valid), 0);

      // flush then reset mid-burst
      step(1, 1, 0, 0, 16'h0, 4'h0);
      for (int i = 0; i < 33; i++) step(1, 0, 1, 0, 16'(i), 4'(i));
      for (int i = 0; i < 22; i++) step(1, 0, 0, 1, 16'h0, 4'h0);
      chk("fl_pre_level", 32'(if0.level), 10);
      chk("fl_pre_ovf", 32'(if0.overflow), 1);
      step(1, 1, 1, 1, 16'h5555, 4'h1);
      chk("fl_level", 32'(if0.level), 0);
      chk("fl_ovf", 32'(if0.overflow), 0);
      chk("fl_empty", 32'(if0.fifo_empty), 1);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 16'(i + 7), 4'(i));
      step(0, 0, 1, 1, 16'h9999, 4'h9);
      chk("rs_level", 32'(if0.level), 0);
      chk("rs_dout", 32'(if0.data_out), 0);
      chk("rs_iout", 32'(if0.index_out), 0);
      chk("rs_valid", 32'(if0.out_valid), 0);
      chk("rs_empty", 32'(if0.fifo_empty), 1);
      chk("rs_full", 32'(if0.fifo_full), 0);
      chk("rs_ae", 32'(if0.almost_empty), 1);
      chk("rs_af", 32'(if0.almost_full), 0);

      // random traffic with shifting read/write bias
      wp = 50; rp = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
         end
         step($urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
              16'($urandom), 4'($urandom));
      end
      step(1, 0, 0, 0, 16'h0, 4'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
